// File: rtl/prog_count_pkg.sv
// Shared types and constants for the programmable BCD counter sequencer.
package prog_count_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, NEXT} state_t;

    localparam int CNT_W   = 7;
    localparam int MAX_BCD = 99;

    // Targets above the counter's BCD range are clamped to its maximum.
    function automatic logic [CNT_W-1:0] sat_bcd(input logic [CNT_W-1:0] v);
        return (v > CNT_W'(MAX_BCD)) ? CNT_W'(MAX_BCD) : v;
    endfunction

endpackage

// File: rtl/prog_count_wdog.sv
// Per-segment watchdog: counts enabled cycles, term flags the cycle on which the count reaches WDOG_CYC.
module prog_count_wdog #(
    parameter int WDOG_CYC = 120
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic term
);
    localparam int W = $clog2(WDOG_CYC + 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign term = en && (cnt_q == W'(WDOG_CYC - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !term) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/prog_count_seq.sv
// Runs the BCD counter through a table of targets, one LOAD/RUN/NEXT segment each, with watchdog and abort.
// Define PROG_COUNT_SEQ_LOOP_EN to add the loop input, which restarts the table after the last segment.
module prog_count_seq
    import prog_count_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int AW       = 2,
    parameter int WDOG_CYC = 120
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cfg_we,
    input  logic [AW-1:0]    cfg_addr,
    input  logic [CNT_W-1:0] cfg_data,
    input  logic [AW:0]      seq_len,
    input  logic             start,
    input  logic             abort,
`ifdef PROG_COUNT_SEQ_LOOP_EN
    input  logic             loop,
`endif
    output logic [CNT_W-1:0] cnt_max,
    output logic             cnt_run,
    input  logic             cnt_stop,
    output logic             busy,
    output logic [AW-1:0]    seg_idx,
    output logic             seg_done,
    output logic             seq_done,
    output logic             err
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_max_q, cnt_max_d;
    logic             cnt_run_q, cnt_run_d;
    logic             busy_q, busy_d;
    logic [AW-1:0]    seg_idx_q, seg_idx_d;
    logic [AW:0]      seq_len_q, seq_len_d;
    logic             seg_done_q, seg_done_d;
    logic             seq_done_q, seq_done_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] tbl_q [DEPTH];
    logic [CNT_W-1:0] tbl_d [DEPTH];

    logic wdog_term;
    logic last_seg;
    logic len_ok;
    logic loop_en;

`ifdef PROG_COUNT_SEQ_LOOP_EN
    assign loop_en = loop;
`else
    assign loop_en = 1'b0;
`endif

    assign last_seg = ({1'b0, seg_idx_q} == (seq_len_q - (AW+1)'(1)));
    assign len_ok   = (seq_len != '0) && (int'(seq_len) <= DEPTH);

    prog_count_wdog #(.WDOG_CYC(WDOG_CYC)) u_wdog (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (state_q != RUN),
        .en   (state_q == RUN),
        .term (wdog_term)
    );

    always_comb begin
        state_d    = state_q;
        cnt_max_d  = cnt_max_q;
        cnt_run_d  = 1'b0;
        busy_d     = busy_q;
        seg_idx_d  = seg_idx_q;
        seq_len_d  = seq_len_q;
        seg_done_d = 1'b0;
        seq_done_d = 1'b0;
        err_d      = err_q;
        tbl_d      = tbl_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (cfg_we && (int'(cfg_addr) < DEPTH)) begin
                    tbl_d[cfg_addr] = sat_bcd(cfg_data);
                end
                if (start && !abort) begin
                    if (len_ok) begin
                        state_d   = LOAD;
                        busy_d    = 1'b1;
                        seg_idx_d = '0;
                        seq_len_d = seq_len;
                        err_d     = 1'b0;
                        cnt_max_d = tbl_q[0];
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d   = RUN;
                    cnt_run_d = 1'b1;
                end
            end
            RUN: begin
                // Abort outranks a same-cycle stop, and a real stop outranks the watchdog.
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_stop) begin
                    state_d    = NEXT;
                    seg_done_d = 1'b1;
                    seq_done_d = last_seg;
                end else if (wdog_term) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_run_d = 1'b1;
                end
            end
            NEXT: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (!last_seg) begin
                    state_d   = LOAD;
                    seg_idx_d = seg_idx_q + AW'(1);
                    cnt_max_d = tbl_q[seg_idx_q + AW'(1)];
                end else if (loop_en) begin
                    state_d   = LOAD;
                    seg_idx_d = '0;
                    cnt_max_d = tbl_q[0];
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_max_q  <= '0;
            cnt_run_q  <= 1'b0;
            busy_q     <= 1'b0;
            seg_idx_q  <= '0;
            seq_len_q  <= '0;
            seg_done_q <= 1'b0;
            seq_done_q <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            cnt_max_q  <= cnt_max_d;
            cnt_run_q  <= cnt_run_d;
            busy_q     <= busy_d;
            seg_idx_q  <= seg_idx_d;
            seq_len_q  <= seq_len_d;
            seg_done_q <= seg_done_d;
            seq_done_q <= seq_done_d;
            err_q      <= err_d;
            tbl_q      <= tbl_d;
        end
    end

    assign cnt_max  = cnt_max_q;
    assign cnt_run  = cnt_run_q;
    assign busy     = busy_q;
    assign seg_idx  = seg_idx_q;
    assign seg_done = seg_done_q;
    assign seq_done = seq_done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_prog_count_seq.sv
// Directed bench for prog_count_seq with a behavioural model of the BCD counter it drives.
module tb_prog_count_seq;
    localparam int AW = 2;

    logic       CLK = 1'b0;
    logic       RST;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [6:0] cfg_data;
    logic [2:0] seq_len;
    logic       start;
    logic       abort;
    logic [6:0] cnt_max;
    logic       cnt_run;
    logic       cnt_stop;
    logic       busy;
    logic [1:0] seg_idx;
    logic       seg_done;
    logic       seq_done;
    logic       err;

    always #5 CLK = ~CLK;

    prog_count_seq dut (
        .CLK      (CLK),
        .RST      (RST),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .seq_len  (seq_len),
        .start    (start),
        .abort    (abort),
        .cnt_max  (cnt_max),
        .cnt_run  (cnt_run),
        .cnt_stop (cnt_stop),
        .busy     (busy),
        .seg_idx  (seg_idx),
        .seg_done (seg_done),
        .seq_done (seq_done),
        .err      (err)
    );

    // Counter model: latches max while run is low, counts from 0 once run rises, stop when count == max.
    logic [6:0] m_cnt;
    logic [6:0] m_max;
    logic       stuck;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_cnt <= '0;
            m_max <= '0;
        end else if (!cnt_run) begin
            m_cnt <= '0;
            m_max <= cnt_max;
        end else if (m_cnt < m_max) begin
            m_cnt <= m_cnt + 7'd1;
        end
    end

    assign cnt_stop = !stuck && cnt_run && (m_cnt == m_max);

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int mb, ms, mq, mboth, mrun, r0, r1, tmo;
    int maxq[$];

    task automatic wr(input int a, input int d);
        cfg_we   = 1'b1;
        cfg_addr = AW'(a);
        cfg_data = 7'(d);
        @(negedge CLK);
        cfg_we   = 1'b0;
    endtask

    // Called with start already raised; watches until busy drops or the budget runs out.
    task automatic run_watch(input int limit);
        mb = 0; ms = 0; mq = 0; mboth = 0; mrun = 0; r0 = -1; r1 = -1; tmo = 1;
        maxq.delete();
        for (int i = 0; i < limit; i++) begin
            @(negedge CLK);
            start = 1'b0;
            if (i == 0) r0 = int'(cnt_run);
            if (i == 1) r1 = int'(cnt_run);
            if (!busy) begin
                tmo = 0;
                break;
            end
            mb++;
            if (cnt_run) mrun++;
            if (seg_done) begin
                ms++;
                maxq.push_back(int'(cnt_max));
            end
            if (seq_done) mq++;
            if (seg_done && seq_done) mboth++;
        end
        check("watch_timeout", tmo, 0);
    endtask

    function automatic int qat(input int i);
        return (i < maxq.size()) ? maxq[i] : -1;
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        seq_len = '0; start = 1'b0; abort = 1'b0; stuck = 1'b0;

        @(negedge CLK);
        check("rst_busy", int'(busy), 0);
        check("rst_run", int'(cnt_run), 0);
        check("rst_max", int'(cnt_max), 0);
        check("rst_idx", int'(seg_idx), 0);
        check("rst_pulses", int'({seg_done, seq_done}), 0);
        check("rst_err", int'(err), 0);
        RST = 1'b0;
        @(negedge CLK);

        // Table {5,0,12,99}, three segments: 8 + 3 + 15 = 26 busy cycles, 6 + 1 + 13 = 20 run cycles.
        wr(0, 5); wr(1, 0); wr(2, 12); wr(3, 99);
        seq_len = 3'd3; start = 1'b1;
        run_watch(200);
        check("t1_load_run", r0, 0);
        check("t1_first_run", r1, 1);
        check("t1_busy_cyc", mb, 26);
        check("t1_run_cyc", mrun, 20);
        check("t1_seg_cnt", ms, 3);
        check("t1_seq_cnt", mq, 1);
        check("t1_seq_with_seg", mboth, 1);
        check("t1_max0", qat(0), 5);
        check("t1_max1", qat(1), 0);
        check("t1_max2", qat(2), 12);
        check("t1_max_held", int'(cnt_max), 12);

        // Over-range target saturates to 99: segments 8 + 102 cycles.
        wr(1, 120);
        seq_len = 3'd2; start = 1'b1;
        run_watch(300);
        check("t2_max0", qat(0), 5);
        check("t2_max1_sat", qat(1), 99);
        check("t2_busy_cyc", mb, 110);

        // Stop never arrives: watchdog ends the segment after exactly 120 run cycles.
        stuck = 1'b1;
        seq_len = 3'd1; start = 1'b1;
        run_watch(300);
        check("t3_run_cyc", mrun, 120);
        check("t3_err", int'(err), 1);
        check("t3_seg_cnt", ms, 0);
        check("t3_seq_cnt", mq, 0);
        check("t3_idle_run", int'(cnt_run), 0);
        stuck = 1'b0;

        // Abort on RUN cycle 3 coincides with stop for target 2.
        wr(0, 2);
        seq_len = 3'd1; start = 1'b1;
        @(negedge CLK); start = 1'b0;
        repeat (3) @(negedge CLK);
        check("t4_stop_seen", int'(cnt_stop), 1);
        check("t4_err_cleared", int'(err), 0);
        abort = 1'b1;
        @(negedge CLK);
        abort = 1'b0;
        check("t4_busy", int'(busy), 0);
        check("t4_run", int'(cnt_run), 0);
        check("t4_seg_done", int'(seg_done), 0);
        check("t4_seq_done", int'(seq_done), 0);
        @(negedge CLK);
        check("t4_no_late_seg", int'(seg_done), 0);

        // Start together with abort in IDLE is dropped, even with a bad length.
        seq_len = 3'd0; start = 1'b1; abort = 1'b1;
        @(negedge CLK);
        start = 1'b0; abort = 1'b0;
        check("t4b_err", int'(err), 0);
        check("t4b_busy", int'(busy), 0);

        // Zero length flags err; a valid start clears it and runs (target 2: 5 cycles).
        seq_len = 3'd0; start = 1'b1;
        run_watch(10);
        check("t5_busy_cyc", mb, 0);
        check("t5_err", int'(err), 1);
        seq_len = 3'd1; start = 1'b1;
        run_watch(50);
        check("t5_err_clr", int'(err), 0);
        check("t5_busy_cyc2", mb, 5);
        check("t5_seg_cnt", ms, 1);
        check("t5_seq_cnt", mq, 1);

        // Reset in the middle of RUN clears outputs at once and wipes the table.
        seq_len = 3'd1; start = 1'b1;
        @(negedge CLK); start = 1'b0;
        repeat (2) @(negedge CLK);
        check("t6_in_run", int'(cnt_run), 1);
        RST = 1'b1;
        #1;
        check("t6_busy", int'(busy), 0);
        check("t6_run", int'(cnt_run), 0);
        check("t6_max", int'(cnt_max), 0);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        seq_len = 3'd1; start = 1'b1;
        run_watch(50);
        check("t6_target0", qat(0), 0);
        check("t6_busy_cyc", mb, 3);
        check("t6_seq_cnt", mq, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
